// File: rtl/mat_pkg.sv
// Shared constants, state encoding and packing helper for the 4x4 Q16.16 matrix datapath.
package mat_pkg;

   localparam int unsigned N    = 4;
   localparam int unsigned W    = 32;
   localparam int unsigned FRAC = 16;

   localparam logic [W-1:0] Q_ONE = 32'h0001_0000;
   localparam logic [W-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [W-1:0] Q_MIN = 32'h8000_0000;

   // Identity in the column-major packed format: entries 0, 5, 10, 15 carry 1.0.
   localparam logic [N*N*W-1:0] Q_IDENT = {Q_ONE, {(4*W){1'b0}},
                                           Q_ONE, {(4*W){1'b0}},
                                           Q_ONE, {(4*W){1'b0}},
                                           Q_ONE};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_DONE
   } mat_state_e;

   function automatic logic [3:0] idx(logic [1:0] r, logic [1:0] c);
      return {c, r};
   endfunction

endpackage

// File: rtl/mat_mul4x4_if.sv
// Request/operand/result bundle of the 4x4 matrix multiplier.
interface mat_mul4x4_if
   import mat_pkg::*;
#(
   parameter int unsigned W = 32
);

   logic               start;
   logic [N*N*W-1:0]   A_in;
   logic [N*N*W-1:0]   B_in;
   logic               busy;
   logic               done;
   logic [N*N*W-1:0]   C_out;

   modport master (output start, A_in, B_in, input busy, done, C_out);
   modport slave  (input start, A_in, B_in, output busy, done, C_out);

endinterface

// File: rtl/mat_mul4x4_q_mac_sat.sv
// Combinational signed MAC step: acc + a*b, then arithmetic shift by FRAC and saturation to W bits.
module q_mac_sat #(
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 16
) (
   input  logic signed [W-1:0]     a,
   input  logic signed [W-1:0]     b,
   input  logic signed [2*W+1:0]   acc,
   output logic signed [2*W+1:0]   sum,
   output logic        [W-1:0]     res
);

   localparam int unsigned ACC_W = 2*W + 2;

   logic signed [2*W-1:0]   prod;
   logic signed [ACC_W-1:0] shifted;

   assign prod    = a * b;
   assign sum     = acc + prod;
   assign shifted = sum >>> FRAC;

   // In range exactly when every bit above the result sign bit matches it.
   always_comb begin
      res = shifted[W-1:0];
      if (!(&shifted[ACC_W-1:W-1]) && (|shifted[ACC_W-1:W-1])) begin
         res = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mat_mul4x4.sv
// Sequential 4x4 Q16.16 matrix multiplier C = A x B, one multiply-accumulate per clock.
module mat_mul4x4 #(
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 16
) (
   input  logic          clk,
   input  logic          rst,
   mat_mul4x4_if.slave   bus
);

   import mat_pkg::*;

   localparam int unsigned ACC_W = 2*W + 2;

   mat_state_e              state_q, state_d;
   logic                    capture;
   logic [1:0]              k_q;
   logic [3:0]              e_q;
   logic [N*N*W-1:0]        a_q, b_q, c_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] sum;
   logic        [W-1:0]     sat;
   logic signed [W-1:0]     a_ent, b_ent;
   logic [1:0]              row, col;

   assign row   = e_q[1:0];
   assign col   = e_q[3:2];
   assign a_ent = a_q[idx(row, k_q)*W +: W];
   assign b_ent = b_q[idx(k_q, col)*W +: W];

   q_mac_sat #(.W(W), .FRAC(FRAC)) u_mac (
      .a   (a_ent),
      .b   (b_ent),
      .acc (acc_q),
      .sum (sum),
      .res (sat)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.start) begin
            state_d = ST_MAC;
            capture = 1'b1;
         end
         ST_MAC: if (e_q == 4'd15 && k_q == 2'd3) state_d = ST_DONE;
         ST_DONE: if (bus.start) begin
            state_d = ST_MAC;
            capture = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         e_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            a_q   <= bus.A_in;
            b_q   <= bus.B_in;
            k_q   <= '0;
            e_q   <= '0;
            acc_q <= '0;
         end else if (state_q == ST_MAC) begin
            k_q <= k_q + 2'd1;
            // Final k folds the last product straight into the write-back.
            if (k_q == 2'd3) begin
               c_q[e_q*W +: W] <= sat;
               acc_q           <= '0;
               e_q             <= e_q + 4'd1;
            end else begin
               acc_q <= sum;
            end
         end
      end
   end

   assign bus.busy  = (state_q == ST_MAC);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.C_out = c_q;

endmodule

// File: doc/mat_mul4x4.md
# mat_mul4x4

Sequential 4x4 fixed-point matrix multiplier, C = A × B, computing one multiply-accumulate per cycle. It performs the forward product that the LU/forward/backward inversion chain undoes. It reconstructs A·X from a matrix and its computed inverse, so the inversion result can be checked against identity in-system. It uses the same 512-bit packed matrix format as the inversion datapath, so it connects directly to that chain's input and output buses.

## Interface
Parameters:
- W, 32: entry width, signed two's complement.
- FRAC, 16: fractional bits (Q16.16; 1.0 = 32'h0001_0000).

Ports:
- clk  in  1: single clock, all logic on rising edge.
- rst  in  1: synchronous, active-low reset.
- start  in  1: one-cycle request; sampled only in IDLE.
- A_in  in  512: left operand, packed 4x4.
- B_in  in  512: right operand, packed 4x4.
- busy  out  1: high while a product is in progress.
- done  out  1: high while C_out holds a valid result.
- C_out  out  512: product, packed 4x4.

Packing is column-major. Entry (r,c), with r,c in 0..3, occupies bits [32*(4c+r)+31 : 32*(4c+r)]. Column c is therefore the 128-bit slice [128c+127:128c].

## Operation
- Operand capture: start in IDLE latches A_in and B_in into internal registers. Input changes after capture have no effect.
- Entry order: entries are computed with index e = 4c+r, from 0 to 15. For each entry, k steps 0..3.
- Accumulation: acc += A[r][k] × B[k][c]. Each product is a full 64-bit signed value; the accumulator is 66-bit signed.
- Write-back at k==3:
  - Compute s = acc + product in the same cycle.
  - Arithmetic-shift s right by FRAC (truncation toward −∞).
  - Saturate to [32'h8000_0000, 32'h7FFF_FFFF].
  - Write the result to C[r][c] and clear acc.
- States:
  - IDLE: start → MAC.
  - MAC: step k and e; when e==15 and k==3, go to DONE.
  - DONE: start → MAC with a new capture; otherwise hold.
- start while in MAC is ignored. No queueing; operands are not recaptured.
- A start in DONE clears done on the next edge. C_out keeps its old value until each entry is overwritten.
- Reset values:
  - state IDLE.
  - busy=0, done=0.
  - C_out=0, acc=0, counters=0, operand registers=0.
- Reset mid-operation: state returns to IDLE on the next edge and the partial result is discarded. done is not asserted for the aborted run.

## Timing
- Cycle 0: start is sampled high at edge 0. busy=1 from after edge 0; k=0, e=0.
- MAC phase: 64 edges, 1 through 64, one MAC per edge. C[e] is updated at edge 4e+4.
- Completion: after edge 64, busy=0 and done=1. Latency from start edge to done is 64 cycles.
- Hold: done stays high and C_out stays stable until the next start or reset.
- Back-to-back operation: start in the first DONE cycle is accepted. Throughput is one product per 65 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package mat_pkg holds:
  - N=4, W=32, FRAC=16.
  - Q_ONE=32'h0001_0000, Q_MAX, Q_MIN.
  - The packed-index helper idx(r,c)=4c+r.
  - The state enum.
- The inversion chain's identity constants should move to the same package.
- One sub-module, q_mac_sat: a combinational 32×32 signed multiply, 66-bit add, shift by FRAC and saturate.
- The top level holds the FSM, the counters, the operand/result registers and the accumulator.

## Test plan
- Identity product: A=I, B=I → after 64 cycles done=1 and C_out=I (diagonal 32'h0001_0000, all else 0).
- Inverse check: A=diag(2.0, 4.0, 0.5, 1.0), B=diag(0.5, 0.25, 2.0, 1.0) → C_out=I exactly.
- Signed arithmetic: A[0][0]=−1.5 (32'hFFFE_8000), B[0][0]=2.0, other entries 0 → C[0][0]=32'hFFFD_0000 (−3.0). Also 1 LSB × 1 LSB → 0 by truncation.
- Saturation: all entries of A and B = 32'h7FFF_FFFF → every C entry = 32'h7FFF_FFFF. With A negated → every C entry = 32'h8000_0000.
- Control:
  - A second start at cycle 10 is ignored and done still rises after edge 64.
  - rst=0 at cycle 30 → busy=0, done=0, C_out=0 on the next edge.
  - A new start afterwards gives the correct result.
- Back-to-back: start again in the first DONE cycle with new operands → done drops for 64 cycles, then the new result appears.
